key_event_encoder: RTL and testbench

//  Front-end stage between the 12 one-hot keypad switches and the calculator core.

---
 rtl/key_event_encoder.sv | 90 +++++++++
 tb/tb_key_event_encoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// key_event_encoder: debounced one-hot keypad encoder feeding a valid/ready event FIFO
// clk, rst (async, active-low)                       : clock and reset
// sw[SW_WIDTH]                                       : raw switches, sw[SW_WIDTH-1] is key 0
// key_ready                                          : consumer takes the head event
// key_valid/key_code/key_digit                       : head event, digit flag set for codes 0..9
// fifo_count, overflow, err_multi                    : queue depth, sticky drop flag, sticky multi-hot flag
module key_event_encoder #(
  parameter int SW_WIDTH        = 12,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SW_WIDTH-1:0]           sw,
  input  logic                          key_ready,
  output logic                          key_valid,
  output logic [3:0]                    key_code,
  output logic                          key_digit,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          err_multi
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 2);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_HIT = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_SAT = CW'(DEBOUNCE_CYCLES + 1);
  localparam logic [PW:0]   FULL    = (PW+1)'(FIFO_DEPTH);
  logic [SW_WIDTH-1:0] s1_q, s2_q, stable_q, stable_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]         count_q, count_d;
  logic                ovf_q, ovf_d, err_q, err_d;
  logic                same, upd, onehot, push, multi, full, pop, wr_en;
  logic [3:0]          code_new;
  // s1_q is the sample about to enter s2_q; the count runs one step past the
  // hit value so that each settled pattern is committed exactly once.
  always_comb begin
    same     = s1_q == s2_q;
    cnt_d    = !same ? '0 : (cnt_q == CNT_SAT ? cnt_q : cnt_q + CW'(1));
    upd      = same && cnt_q == CNT_HIT;
    onehot   = $onehot(s2_q);
    push     = upd && onehot && s2_q != stable_q;
    multi    = upd && !onehot && |s2_q;
    stable_d = upd ? s2_q : stable_q;
    full     = count_q == FULL;
    pop      = key_valid && key_ready;
    wr_en    = push && (!full || pop);
    wr_d     = wr_q + PW'(wr_en);
    rd_d     = rd_q + PW'(pop);
    count_d  = count_q + (PW+1)'(wr_en) - (PW+1)'(pop);
    ovf_d    = ovf_q || (push && full && !pop);
    err_d    = err_q || multi;
  end
  always_comb begin
    code_new = '0;
    for (int i = 0; i < SW_WIDTH; i++)
      if (s2_q[i]) code_new = 4'(SW_WIDTH - 1 - i);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_q     <= sw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= code_new;
  assign key_valid  = count_q != '0;
  assign key_code   = key_valid ? mem_q[rd_q] : '0;
  assign key_digit  = key_valid && key_code <= 4'd9;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign err_multi  = err_q;
endmodule

// File: tb/tb_key_event_encoder.sv
// tb_key_event_encoder: directed self-checking bench for key_event_encoder
module tb_key_event_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] sw = '0;
  logic        key_ready = 1'b0;
  logic        key_valid, key_digit, overflow, err_multi;
  logic [3:0]  key_code;
  logic [2:0]  fifo_count;
  int          checks = 0;
  int          failures = 0;
  int          vcnt = 0;
  int          v0;
  logic [4:0]  popped[$];
  key_event_encoder dut (
    .clk(clk), .rst(rst), .sw(sw), .key_ready(key_ready),
    .key_valid(key_valid), .key_code(key_code), .key_digit(key_digit),
    .fifo_count(fifo_count), .overflow(overflow), .err_multi(err_multi)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (key_valid) begin
      vcnt <= vcnt + 1;
      if (key_ready) popped.push_back({key_digit, key_code});
    end
  function automatic logic [11:0] key(input int k);
    logic [11:0] one;
    one = 12'd1;
    return one << (11 - k);
  endfunction
  function automatic logic [4:0] ev(input int k);
    return {k <= 9, 4'(k)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic press(input logic [11:0] v, input int n);
    sw = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic chk_pop(input string tag, input int idx, input int k);
    chk(tag, 32'(idx < popped.size() ? popped[idx] : 5'h1f), 32'(ev(k)));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_code", 32'(key_code), 0);
    chk("rst_flags", 32'({overflow, err_multi, key_digit}), 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    // keys 0..11 back to back, consumer always ready
    key_ready = 1'b1;
    popped.delete();
    v0 = vcnt;
    sw = key(0);
    repeat (6) @(negedge clk);
    chk("lat_edge6_valid", 32'(key_valid), 0);
    @(negedge clk);
    chk("lat_edge7_valid", 32'(key_valid), 1);
    chk("lat_edge7_code", 32'(key_code), 0);
    chk("lat_edge7_digit", 32'(key_digit), 1);
    repeat (3) @(negedge clk);
    for (int k = 1; k < 12; k++) press(key(k), 10);
    press('0, 10);
    chk("seq_pop_count", popped.size(), 12);
    for (int k = 0; k < 12; k++) chk_pop("seq_pop", k, k);
    chk("seq_valid_cycles", vcnt - v0, 12);
    // glitches shorter than the debounce window
    popped.delete();
    v0 = vcnt;
    press(12'b0000_0001_0000, 2);
    press('0, 15);
    chk("glitch2_valid_cycles", vcnt - v0, 0);
    chk("glitch2_count", 32'(fifo_count), 0);
    press(key(3), 5);
    press('0, 12);
    chk("glitch5_valid_cycles", vcnt - v0, 0);
    press(key(3), 6);
    press('0, 12);
    chk("hold6_valid_cycles", vcnt - v0, 1);
    chk_pop("hold6_code", 0, 3);
    // stable multi-hot pattern
    v0 = vcnt;
    press(12'b0000_0000_0011, 20);
    chk("multi_err", 32'(err_multi), 1);
    chk("multi_count", 32'(fifo_count), 0);
    chk("multi_valid_cycles", vcnt - v0, 0);
    press('0, 10);
    chk("multi_sticky", 32'(err_multi), 1);
    // stalled consumer: fill then overflow
    key_ready = 1'b0;
    popped.delete();
    for (int k = 1; k <= 4; k++) press(key(k), 10);
    chk("fill_count", 32'(fifo_count), 4);
    chk("fill_ovf", 32'(overflow), 0);
    press(key(5), 10);
    chk("ovf_count", 32'(fifo_count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    press('0, 10);
    chk("ovf_head_valid", 32'(key_valid), 1);
    chk("ovf_head_code", 32'(key_code), 1);
    key_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("drain_count", 32'(fifo_count), 0);
    chk("drain_pops", popped.size(), 4);
    for (int k = 0; k < 4; k++) chk_pop("drain_pop", k, k + 1);
    // asynchronous reset with three events queued and key 4 still held
    key_ready = 1'b0;
    for (int k = 2; k <= 4; k++) press(key(k), 10);
    chk("prerst_count", 32'(fifo_count), 3);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(key_valid), 0);
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_flags", 32'({overflow, err_multi}), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("held_edge6_valid", 32'(key_valid), 0);
    @(negedge clk);
    chk("held_edge7_valid", 32'(key_valid), 1);
    chk("held_edge7_code", 32'(key_code), 4);
    chk("held_edge7_count", 32'(fifo_count), 1);
    press('0, 10);
    chk("held_single_event", 32'(fifo_count), 1);
    key_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_drain", 32'(fifo_count), 0);
    // long hold, release, re-press
    popped.delete();
    v0 = vcnt;
    press(key(7), 50);
    press('0, 10);
    press(key(7), 10);
    press('0, 10);
    chk("repress_valid_cycles", vcnt - v0, 2);
    chk("repress_pops", popped.size(), 2);
    chk_pop("repress_pop0", 0, 7);
    chk_pop("repress_pop1", 1, 7);
    // push and pop on the same edge while full
    key_ready = 1'b0;
    popped.delete();
    for (int k = 1; k <= 4; k++) press(key(k), 10);
    chk("pp_full_count", 32'(fifo_count), 4);
    sw = key(6);
    repeat (6) @(negedge clk);
    chk("pp_pre_count", 32'(fifo_count), 4);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    chk("pp_count", 32'(fifo_count), 4);
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_head", 32'(key_code), 2);
    repeat (3) @(negedge clk);
    press('0, 10);
    key_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("pp_drain_count", 32'(fifo_count), 0);
    chk("pp_pops", popped.size(), 5);
    chk_pop("pp_pop0", 0, 1);
    chk_pop("pp_pop1", 1, 2);
    chk_pop("pp_pop2", 2, 3);
    chk_pop("pp_pop3", 3, 4);
    chk_pop("pp_pop4", 4, 6);
    chk("pp_final_ovf", 32'(overflow), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
